// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_DM = 2'd2,
        RESP     = 2'd3
    } state_e;

    localparam logic [2:0] FETCH_F3    = 3'b010;
    localparam int         TIMEOUT_DEF = 15;
    localparam int         IF_IDX      = 0;
    localparam int         DM_IDX      = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-requester round-robin selector; on a tie the side not served last wins.
module rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // last = 1 means the DM side was served most recently
    always_comb begin
        grant = 2'b00;
        if (req[IF_IDX] && req[DM_IDX]) begin
            grant[IF_IDX] = last;
            grant[DM_IDX] = ~last;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// with round-robin arbitration and a bounded wait for mem_ack.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [2:0]        dm_funct3,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic              busy
);

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic       last_q;      // 1 = DM served last; also the owner while busy
    logic [1:0] grant;
    logic [7:0] wait_cnt;
    logic       serving;
    logic       abort;

    rr_arbiter2 u_rr (
        .req   ({dm_req, if_req}),
        .last  (last_q),
        .grant (grant)
    );

    assign serving = (state_q == SERVE_IF) || (state_q == SERVE_DM);
    assign mem_req = serving;
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant[DM_IDX])      state_d = SERVE_DM;
                else if (grant[IF_IDX]) state_d = SERVE_IF;
            end
            SERVE_IF, SERVE_DM: begin
                if (mem_ack) begin
                    state_d = RESP;
                end else if (wait_cnt + 8'd1 == TO_CNT) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b0;
            wait_cnt   <= '0;
            if_gnt     <= 1'b0;
            dm_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= '0;
            err        <= 1'b0;
        end else begin
            state_q   <= state_d;
            if_gnt    <= 1'b0;
            dm_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            dm_rvalid <= 1'b0;
            err       <= 1'b0;
            if (state_q == IDLE && (|grant)) begin
                last_q   <= grant[DM_IDX];
                if_gnt   <= grant[IF_IDX];
                dm_gnt   <= grant[DM_IDX];
                wait_cnt <= '0;
                if (grant[DM_IDX]) begin
                    mem_we     <= dm_we;
                    mem_addr   <= dm_addr;
                    mem_wdata  <= dm_wdata;
                    mem_funct3 <= dm_funct3;
                end else begin
                    mem_we     <= 1'b0;
                    mem_addr   <= if_addr;
                    mem_wdata  <= '0;
                    mem_funct3 <= FETCH_F3;
                end
            end
            if (serving) begin
                if (mem_ack) begin
                    if (last_q) begin
                        dm_rdata  <= mem_rdata;
                        dm_rvalid <= 1'b1;
                    end else begin
                        if_rdata  <= mem_rdata;
                        if_rvalid <= 1'b1;
                    end
                end else begin
                    wait_cnt <= wait_cnt + 8'd1;
                    // abandoned access completes with zero data and an err pulse
                    if (abort) begin
                        err <= 1'b1;
                        if (last_q) begin
                            dm_rdata  <= '0;
                            dm_rvalid <= 1'b1;
                        end else begin
                            if_rdata  <= '0;
                            if_rvalid <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized transaction bench for mem_port_arbiter.
module tb_mem_port_arbiter;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [2:0]  dm_funct3;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_funct3;
    logic        err, busy;

    int          vectors = 0;
    int          miscompares = 0;

    // transaction-level reference state
    bit          last_if = 1'b1;
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_dm_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_funct3(dm_funct3),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .err(err), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, "_if_gnt"}, if_gnt, 1'b0);
        chk1({tag, "_dm_gnt"}, dm_gnt, 1'b0);
        chk1({tag, "_if_rvalid"}, if_rvalid, 1'b0);
        chk1({tag, "_dm_rvalid"}, dm_rvalid, 1'b0);
        chkw({tag, "_if_rdata"}, if_rdata, 32'h0);
        chkw({tag, "_dm_rdata"}, dm_rdata, 32'h0);
        chk1({tag, "_mem_req"}, mem_req, 1'b0);
        chk1({tag, "_mem_we"}, mem_we, 1'b0);
        chkw({tag, "_mem_addr"}, mem_addr, 32'h0);
        chkw({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chkw({tag, "_mem_funct3"}, {29'd0, mem_funct3}, 32'h0);
        chk1({tag, "_err"}, err, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
    endtask

    task automatic chk_rdata(input string tag);
        chkw({tag, "_if_rdata"}, if_rdata, exp_if_rdata);
        chkw({tag, "_dm_rdata"}, dm_rdata, exp_dm_rdata);
    endtask

    // One arbitrated access, entered at the start of an IDLE cycle.
    // dly = cycle (counted from the grant cycle) in which mem_ack is given;
    // dly >= TO means the memory never answers.
    task automatic txn(input bit ir, input bit dr, input logic [31:0] ia,
                       input bit we, input logic [31:0] da, input logic [31:0] wd,
                       input logic [2:0] f3, input int dly, input logic [31:0] ad);
        bit          dm_wins;
        logic [31:0] ea;
        logic        ewe;
        logic [2:0]  ef3;
        if_req = ir; if_addr = ia;
        dm_req = dr; dm_we = we; dm_addr = da; dm_wdata = wd; dm_funct3 = f3;
        mem_ack = 1'b0;
        chk1("idle_busy", busy, 1'b0);
        dm_wins = dr && (!ir || last_if);
        last_if = !dm_wins;
        ea  = dm_wins ? da : ia;
        ewe = dm_wins ? we : 1'b0;
        ef3 = dm_wins ? f3 : 3'b010;
        for (int k = 0; k < TO; k++) begin
            tick();
            chk1("serve_if_gnt", if_gnt, (k == 0) && !dm_wins);
            chk1("serve_dm_gnt", dm_gnt, (k == 0) && dm_wins);
            chk1("serve_mem_req", mem_req, 1'b1);
            chk1("serve_busy", busy, 1'b1);
            chkw("serve_mem_addr", mem_addr, ea);
            chk1("serve_mem_we", mem_we, ewe);
            chkw("serve_mem_funct3", {29'd0, mem_funct3}, {29'd0, ef3});
            if (dm_wins && we) chkw("serve_mem_wdata", mem_wdata, wd);
            chk1("serve_if_rvalid", if_rvalid, 1'b0);
            chk1("serve_dm_rvalid", dm_rvalid, 1'b0);
            chk1("serve_err", err, 1'b0);
            chk_rdata("serve");
            if (k == 0) begin
                if (dm_wins) dm_req = 1'b0; else if_req = 1'b0;
            end
            mem_ack   = (k == dly);
            mem_rdata = (k == dly) ? ad : $urandom;
            if (k == dly) break;
        end
        if (dly < TO) begin
            tick();
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            if (dm_wins) exp_dm_rdata = ad; else exp_if_rdata = ad;
            chk1("resp_if_rvalid", if_rvalid, !dm_wins);
            chk1("resp_dm_rvalid", dm_rvalid, dm_wins);
            chk1("resp_mem_req", mem_req, 1'b0);
            chk1("resp_busy", busy, 1'b1);
            chk1("resp_err", err, 1'b0);
            chk1("resp_gnt", if_gnt | dm_gnt, 1'b0);
            chk_rdata("resp");
            tick();
            mem_ack = 1'b0;
            chk1("post_busy", busy, 1'b0);
            chk1("post_rvalid", if_rvalid | dm_rvalid, 1'b0);
            chk1("post_err", err, 1'b0);
            chk1("post_mem_req", mem_req, 1'b0);
            chk_rdata("post");
        end else begin
            tick();
            if (dm_wins) exp_dm_rdata = '0; else exp_if_rdata = '0;
            chk1("to_mem_req", mem_req, 1'b0);
            chk1("to_err", err, 1'b1);
            chk1("to_if_rvalid", if_rvalid, !dm_wins);
            chk1("to_dm_rvalid", dm_rvalid, dm_wins);
            chk1("to_busy", busy, 1'b0);
            chk_rdata("to");
        end
    endtask

    initial begin
        logic [31:0] held_if, held_dm;
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_funct3 = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();

        // single fetch
        txn(1'b1, 1'b0, 32'h0000_0010, 1'b0, '0, '0, 3'b000, 0, 32'h0000_0013);
        // ties: DM first, then alternate
        for (int i = 0; i < 4; i++)
            txn(1'b1, 1'b1, 32'h200 + 32'(i), 1'b0, 32'h300 + 32'(i), '0, 3'b010, 0,
                32'hA000_0000 + 32'(i));
        // store, held for a few wait cycles
        txn(1'b0, 1'b1, '0, 1'b1, 32'h100, 32'hDEAD_BEEF, 3'b010, 3, 32'h1234_5678);
        // timeout on the data side
        txn(1'b0, 1'b1, '0, 1'b0, 32'h400, '0, 3'b100, 99, 32'h0);

        // stray ack in IDLE
        held_if = exp_if_rdata; held_dm = exp_dm_rdata;
        if_req = 1'b0; dm_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        tick();
        mem_ack = 1'b0;
        chk1("stray_rvalid", if_rvalid | dm_rvalid, 1'b0);
        chk1("stray_busy", busy, 1'b0);
        chkw("stray_if_rdata", if_rdata, held_if);
        chkw("stray_dm_rdata", dm_rdata, held_dm);

        // reset in the middle of a fetch
        txn(1'b1, 1'b0, 32'h0000_0044, 1'b0, '0, '0, 3'b000, 1, 32'h5555_AAAA);
        if_req = 1'b1; if_addr = 32'h0000_0080;
        tick();
        chk1("mid_if_gnt", if_gnt, 1'b1);
        if_req = 1'b0;
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
        tick();
        mem_ack = 1'b0;
        chk_all_zero("midrst");
        rst = 1'b1;
        last_if = 1'b1; exp_if_rdata = '0; exp_dm_rdata = '0;
        tick();
        chk1("midrst_after_rvalid", if_rvalid | dm_rvalid, 1'b0);
        chk1("midrst_after_err", err, 1'b0);
        chk1("midrst_after_busy", busy, 1'b0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            int          r, d;
            r = $urandom_range(1, 3);
            d = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(0, 4);
            txn(r[0], r[1], $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
                3'($urandom_range(0, 7)), d, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
